avalon_lsu_bridge: RTL and testbench
====================================

AVALON_LSU_BRIDGE -- requirements
Module: avalon_lsu_bridge

Interface
REQ-001 Parameter READ_LATENCY, default 1, memory read latency in cycles from the address-sampling edge; legal values 1 or 2.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req_valid  input  1  core request present.
REQ-005 req_ready  output  1  bridge accepts a request this cycle.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-008 req_unsigned  input  1  load zero-extends when 1 and sign-extends when 0.
REQ-009 req_addr  input  12  byte address.
REQ-010 req_wdata  input  32  store data, right-aligned.
REQ-011 rsp_valid  output  1  one-cycle response pulse.
REQ-012 rsp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-013 rsp_err  output  1  misaligned or illegal-size request, qualified by rsp_valid.
REQ-014 mem_address  output  10  word address, equal to req_addr[11:2].
REQ-015 mem_byteenable  output  4  byte lanes.
REQ-016 mem_chipselect  output  1  memory access strobe.
REQ-017 mem_write  output  1  write strobe.
REQ-018 mem_writedata  output  32  lane-replicated store data.
REQ-019 mem_clken  output  1  constant 1.
REQ-020 mem_readdata  input  32  memory read data.

Function
REQ-021 The FSM SHALL have the states IDLE, ACCESS, WAIT, RESP; req_ready is 1 only in IDLE; a request is accepted on req_valid & req_ready.
REQ-022 Misalignment SHALL be detected on accept (half with addr[0]=1, word with addr[1:0]≠0, size 11); IDLE goes to RESP, no memory strobe, and rsp_err=1 in RESP.
REQ-023 A legal request SHALL register all mem_* outputs at accept and go to ACCESS.
REQ-024 In ACCESS, mem_chipselect SHALL be 1 for exactly one cycle, with mem_write=req_we.
REQ-025 A store SHALL transition ACCESS→RESP.
REQ-026 A load SHALL transition ACCESS→WAIT.
REQ-027 WAIT SHALL last READ_LATENCY cycles, counted by a latency counter, and capture the extended mem_readdata into rsp_rdata on its last cycle; then WAIT→RESP.
REQ-028 RESP SHALL assert rsp_valid for one cycle, then return to IDLE; responses have no backpressure.
REQ-029 Latency from the accept cycle T SHALL be: error rsp_valid at T+1; store rsp_valid at T+2; load rsp_valid at T+2+READ_LATENCY.
REQ-030 Byteenable SHALL be: byte 0001<<addr[1:0]; half 0011<<(2*addr[1]); word 1111.
REQ-031 mem_writedata SHALL be: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word wdata.
REQ-032 Load lane SHALL be selected by addr[1:0] (byte) or addr[1] (half), then extended to 32 bits per req_unsigned.
REQ-033 Size, unsigned and lane bits SHALL be held in registers for the duration of the transaction.
REQ-034 Outside ACCESS, mem_chipselect=0, mem_write=0 and mem_byteenable=0000; mem_address and mem_writedata hold their last value.
REQ-035 Requests presented while req_ready=0 SHALL be ignored; req_valid in the RESP cycle is not accepted until IDLE.

Reset
REQ-036 On reset=1 at a clock edge, the state SHALL become IDLE and all outputs SHALL be 0 except req_ready=1 and mem_clken=1.
REQ-037 Reset mid-transaction (ACCESS/WAIT/RESP) SHALL abort the transaction: no rsp_valid and no further memory strobe after the reset edge.
REQ-038 The latency counter and the captured lane/size registers SHALL clear on reset.

Verification
REQ-039 Word store addr 0x010, wdata 0xDEADBEEF -> ACCESS: address 0x004, byteenable 1111, write=1; rsp_valid at T+2, rsp_err=0.
REQ-040 Byte store addr 0x013, wdata 0x000000A5 -> byteenable 1000, writedata 0xA5A5A5A5; then signed byte load addr 0x013 with readdata 0xA5xxxxxx -> rsp_rdata 0xFFFFFFA5 at T+3 (READ_LATENCY=1).
REQ-041 Unsigned half load addr 0x022 with readdata 0x8001_1234 -> rsp_rdata 0x00008001; the same load signed -> 0xFFFF8001; with READ_LATENCY=2, response at T+4.
REQ-042 Half load addr 0x001, word store addr 0x002, size 11 -> rsp_err=1 at T+1, mem_chipselect never asserted, rsp_rdata=0.
REQ-043 Back-to-back req_valid held high -> accepts only in IDLE cycles, exactly one rsp_valid per accepted request.
REQ-044 Reset asserted in WAIT -> next cycle IDLE, req_ready=1, no rsp_valid; a subsequent word load completes normally.

Source files
------------

// File: rtl/avalon_lsu_bridge.sv
// Load/store bridge from a simple core request port to an Avalon-MM on-chip memory.
// Handles one transaction at a time; misaligned or illegal-size requests get an error response.
module avalon_lsu_bridge #(
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [11:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [9:0]  mem_address,
  output logic [3:0]  mem_byteenable,
  output logic        mem_chipselect,
  output logic        mem_write,
  output logic [31:0] mem_writedata,
  output logic        mem_clken,
  input  logic [31:0] mem_readdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_e;

  state_e      state_q, state_d;
  logic [9:0]  addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [1:0]  lane_q, lane_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        misalign;
  logic [3:0]  be_calc;
  logic [31:0] wdata_calc;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  always_comb begin
    misalign = (req_size == 2'b11) ||
               ((req_size == 2'b01) && req_addr[0]) ||
               ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
    case (req_size)
      2'b00:   be_calc = 4'b0001 << req_addr[1:0];
      2'b01:   be_calc = req_addr[1] ? 4'b1100 : 4'b0011;
      default: be_calc = 4'b1111;
    endcase
    case (req_size)
      2'b00:   wdata_calc = {4{req_wdata[7:0]}};
      2'b01:   wdata_calc = {2{req_wdata[15:0]}};
      default: wdata_calc = req_wdata;
    endcase
  end

  // Load extraction uses the lane/size captured at accept, not the live request.
  always_comb begin
    case (lane_q)
      2'd0:    ld_byte = mem_readdata[7:0];
      2'd1:    ld_byte = mem_readdata[15:8];
      2'd2:    ld_byte = mem_readdata[23:16];
      default: ld_byte = mem_readdata[31:24];
    endcase
    ld_half = lane_q[1] ? mem_readdata[31:16] : mem_readdata[15:0];
    case (size_q)
      2'b00:   ld_ext = uns_q ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      2'b01:   ld_ext = uns_q ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: ld_ext = mem_readdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    lane_d  = lane_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          rdata_d = '0;
          err_d   = misalign;
          we_d    = req_we;
          size_d  = req_size;
          uns_d   = req_unsigned;
          lane_d  = req_addr[1:0];
          if (misalign) begin
            state_d = RESP;
          end else begin
            state_d = ACCESS;
            addr_d  = req_addr[11:2];
            be_d    = be_calc;
            wdata_d = wdata_calc;
          end
        end
      end
      ACCESS: begin
        if (we_q) begin
          state_d = RESP;
        end else begin
          state_d = WAIT;
          cnt_d   = 2'(READ_LATENCY - 1);
        end
      end
      WAIT: begin
        if (cnt_q == 2'd0) begin
          rdata_d = ld_ext;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      lane_q  <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      lane_q  <= lane_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign req_ready      = (state_q == IDLE);
  assign rsp_valid      = (state_q == RESP);
  assign rsp_err        = rsp_valid && err_q;
  assign rsp_rdata      = rdata_q;
  assign mem_chipselect = (state_q == ACCESS);
  assign mem_write      = mem_chipselect && we_q;
  assign mem_byteenable = mem_chipselect ? be_q : '0;
  assign mem_address    = addr_q;
  assign mem_writedata  = wdata_q;
  assign mem_clken      = 1'b1;

endmodule

// File: tb/tb_avalon_lsu_bridge.sv
// Bench for avalon_lsu_bridge: two instances (read latency 1 and 2), each behind a
// behavioural memory, checked against a byte-addressed shadow of memory contents.
module tb_avalon_lsu_bridge;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req_valid;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [11:0] req_addr;
  logic [31:0] req_wdata;
  int unsigned sel;

  logic [1:0]  vld_w, ready_w, rvalid_w, err_w, cs_w, wr_w, clken_w;
  logic [31:0] rdata_w [2];
  logic [31:0] wdo_w [2];
  logic [31:0] rd_in [2];
  logic [9:0]  addr_w [2];
  logic [3:0]  be_w [2];

  int n_cmp = 0;
  int n_bad = 0;

  assign vld_w[0] = req_valid && (sel == 0);
  assign vld_w[1] = req_valid && (sel == 1);

  avalon_lsu_bridge #(.READ_LATENCY(1)) u0 (
    .clk(clk), .reset(reset), .req_valid(vld_w[0]), .req_ready(ready_w[0]),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rvalid_w[0]),
    .rsp_rdata(rdata_w[0]), .rsp_err(err_w[0]), .mem_address(addr_w[0]),
    .mem_byteenable(be_w[0]), .mem_chipselect(cs_w[0]), .mem_write(wr_w[0]),
    .mem_writedata(wdo_w[0]), .mem_clken(clken_w[0]), .mem_readdata(rd_in[0])
  );

  avalon_lsu_bridge #(.READ_LATENCY(2)) u1 (
    .clk(clk), .reset(reset), .req_valid(vld_w[1]), .req_ready(ready_w[1]),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rvalid_w[1]),
    .rsp_rdata(rdata_w[1]), .rsp_err(err_w[1]), .mem_address(addr_w[1]),
    .mem_byteenable(be_w[1]), .mem_chipselect(cs_w[1]), .mem_write(wr_w[1]),
    .mem_writedata(wdo_w[1]), .mem_clken(clken_w[1]), .mem_readdata(rd_in[1])
  );

  // Behavioural synchronous memories: data appears 1 (u0) or 2 (u1) cycles after the address edge.
  logic [31:0] mem [2][1024];
  logic [31:0] p0 [2];
  logic [31:0] p1 [2];

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (cs_w[k] && wr_w[k]) mem[k][addr_w[k]] <= merge(mem[k][addr_w[k]], wdo_w[k], be_w[k]);
      if (cs_w[k] && !wr_w[k]) p0[k] <= mem[k][addr_w[k]];
      p1[k] <= p0[k];
    end
  end
  assign rd_in[0] = p0[0];
  assign rd_in[1] = p1[1];

  logic [7:0] shadow [2][4096];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issues one request on instance `sel` and checks every cycle until it is back in IDLE.
  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [11:0] addr, input logic [31:0] wdata);
    int unsigned nbytes, lat, rl, n;
    logic err;
    logic [3:0] exp_be;
    logic [31:0] exp_wd, v, exp_rd;
    nbytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    err = (size == 2'd3) || (addr % nbytes != 0);
    rl  = sel + 1;
    lat = err ? 1 : (we ? 2 : 2 + rl);
    exp_be = '0;
    exp_wd = '0;
    for (int unsigned i = 0; i < nbytes; i++) exp_be[addr[1:0] + i] = 1'b1;
    for (int unsigned b = 0; b < 4; b++) exp_wd[8*b +: 8] = wdata[8*(b % nbytes) +: 8];
    v = '0;
    if (!err) for (int unsigned i = 0; i < nbytes; i++) v[8*i +: 8] = shadow[sel][addr + i];
    if (err || we)      exp_rd = 0;
    else if (uns)       exp_rd = v;
    else if (nbytes==1) exp_rd = {{24{v[7]}}, v[7:0]};
    else if (nbytes==2) exp_rd = {{16{v[15]}}, v[15:0]};
    else                exp_rd = v;

    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    n = 0;
    while (!ready_w[sel] && n < 20) begin @(negedge clk); n++; end
    check("accept_ready", 32'(ready_w[sel]), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    for (int unsigned k = 1; k <= lat + 1; k++) begin
      check("chipselect", 32'(cs_w[sel]), 32'((k == 1) && !err));
      check("rsp_valid", 32'(rvalid_w[sel]), 32'(k == lat));
      if (k == 1 && !err) begin
        check("mem_address", 32'(addr_w[sel]), 32'(addr >> 2));
        check("byteenable", 32'(be_w[sel]), 32'(exp_be));
        check("mem_write", 32'(wr_w[sel]), 32'(we));
        if (we) check("writedata", wdo_w[sel], exp_wd);
      end
      if (k == lat) begin
        check("rsp_err", 32'(err_w[sel]), 32'(err));
        check("rsp_rdata", rdata_w[sel], exp_rd);
      end
      if (k == lat + 1) check("ready_after", 32'(ready_w[sel]), 32'd1);
      else check("ready_busy", 32'(ready_w[sel]), 32'd0);
      if (k <= lat) @(negedge clk);
    end
    if (we && !err) for (int unsigned i = 0; i < nbytes; i++) shadow[sel][addr + i] = wdata[8*i +: 8];
  endtask

  initial begin
    int unsigned acc, rsp, n;
    for (int k = 0; k < 2; k++) for (int i = 0; i < 4096; i++) shadow[k][i] = 8'h00;
    sel = 0; reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = '0;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      check("rst_ready", 32'(ready_w[k]), 32'd1);
      check("rst_rsp_valid", 32'(rvalid_w[k]), 32'd0);
      check("rst_rsp_err", 32'(err_w[k]), 32'd0);
      check("rst_rdata", rdata_w[k], 32'd0);
      check("rst_cs_wr_be", {26'd0, cs_w[k], wr_w[k], be_w[k]}, 32'd0);
      check("rst_addr", 32'(addr_w[k]), 32'd0);
      check("rst_wdata", wdo_w[k], 32'd0);
      check("rst_clken", 32'(clken_w[k]), 32'd1);
    end

    // Preload the low 256 bytes of each memory through the bridge.
    for (int k = 0; k < 2; k++) begin
      sel = k;
      for (int unsigned w = 0; w < 64; w++) do_req(1'b1, 2'd2, 1'b0, 12'(w * 4), $urandom);
    end

    sel = 0;
    do_req(1'b1, 2'd2, 1'b0, 12'h010, 32'hDEADBEEF);
    do_req(1'b1, 2'd0, 1'b0, 12'h013, 32'h000000A5);
    do_req(1'b0, 2'd0, 1'b0, 12'h013, 32'h0);
    do_req(1'b1, 2'd2, 1'b0, 12'h020, 32'h80011234);
    do_req(1'b0, 2'd1, 1'b1, 12'h022, 32'h0);
    do_req(1'b0, 2'd1, 1'b0, 12'h022, 32'h0);
    do_req(1'b0, 2'd1, 1'b0, 12'h001, 32'h0);
    do_req(1'b1, 2'd2, 1'b0, 12'h002, 32'h12345678);
    do_req(1'b0, 2'd3, 1'b0, 12'h010, 32'h0);
    do_req(1'b1, 2'd2, 1'b0, 12'hFF0, 32'h0BADF00D);
    sel = 1;
    do_req(1'b1, 2'd2, 1'b0, 12'h020, 32'h80011234);
    do_req(1'b0, 2'd1, 1'b1, 12'h022, 32'h0);
    do_req(1'b0, 2'd1, 1'b0, 12'h022, 32'h0);
    do_req(1'b1, 2'd0, 1'b0, 12'h013, 32'h000000A5);
    do_req(1'b0, 2'd0, 1'b0, 12'h013, 32'h0);
    do_req(1'b0, 2'd3, 1'b1, 12'h000, 32'h0);

    for (int k = 0; k < 2; k++) begin
      sel = k;
      for (int t = 0; t < 60; t++)
        do_req(1'($urandom), 2'($urandom), 1'($urandom), 12'($urandom_range(0, 255)), $urandom);
    end

    // Request held high: a store occupies IDLE, ACCESS, RESP, so 30 cycles admit 10 accepts.
    sel = 0; acc = 0; rsp = 0;
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 12'h040; req_wdata = 32'hCAFE0001;
    for (int c = 0; c < 30; c++) begin
      if (ready_w[0]) acc++;
      if (rvalid_w[0]) rsp++;
      @(negedge clk);
    end
    req_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (rvalid_w[0]) rsp++;
      @(negedge clk);
    end
    for (int unsigned i = 0; i < 4; i++) shadow[0][12'h040 + i] = req_wdata[8*i +: 8];
    check("b2b_accepts", acc, 32'd10);
    check("b2b_responses", rsp, acc);
    do_req(1'b0, 2'd2, 1'b0, 12'h040, 32'h0);

    // Reset while the latency-2 instance is in WAIT.
    sel = 1;
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 12'h010;
    n = 0;
    while (!ready_w[1] && n < 20) begin @(negedge clk); n++; end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      check("abort_ready", 32'(ready_w[1]), 32'd1);
      check("abort_rsp_valid", 32'(rvalid_w[1]), 32'd0);
      check("abort_cs", 32'(cs_w[1]), 32'd0);
      @(negedge clk);
    end
    check("abort_rdata", rdata_w[1], 32'd0);
    do_req(1'b0, 2'd2, 1'b0, 12'h010, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
